conv2_buf: RTL and testbench

Sliding-window line buffer that feeds the second convolution layer. It accepts one channel of the pooled conv1 feature map as a raster-scan stream of signed 12-bit pixels. For every valid 5x5 window position it presents the 25 window pixels on parallel outputs, together with a single-cycle `valid_out_buf` pulse. Three instances, one per input channel and sharing `clk`/`rst_n`/`valid_in`, drive the `data_out1_*`, `data_out2_*` and `data_out3_*` inputs of the conv2 calculation blocks.

---
 rtl/conv2_buf.sv | 146 ++++++++++++++
 tb/tb_conv2_buf.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_buf.sv
// conv2_buf: 5x5 sliding-window line buffer feeding the conv2 layer.
// One pooled conv1 channel arrives as a raster-scan stream of signed pixels.
// After each accepted pixel whose position completes a full 5x5 window, the
// 25 window pixels are presented on data_out_* with a one-cycle valid_out_buf.
// Optional feature: define CONV2_BUF_SOF_EN to add the sof_in port, which
// re-aligns the raster counters to pixel (0,0) on the marked pixel.
module conv2_buf #(
  parameter int WIDTH     = 12,
  parameter int HEIGHT    = 12,
  parameter int DATA_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in,
`ifdef CONV2_BUF_SOF_EN
  input  logic                 sof_in,
`endif
  output logic [DATA_BITS-1:0] data_out_0,
  output logic [DATA_BITS-1:0] data_out_1,
  output logic [DATA_BITS-1:0] data_out_2,
  output logic [DATA_BITS-1:0] data_out_3,
  output logic [DATA_BITS-1:0] data_out_4,
  output logic [DATA_BITS-1:0] data_out_5,
  output logic [DATA_BITS-1:0] data_out_6,
  output logic [DATA_BITS-1:0] data_out_7,
  output logic [DATA_BITS-1:0] data_out_8,
  output logic [DATA_BITS-1:0] data_out_9,
  output logic [DATA_BITS-1:0] data_out_10,
  output logic [DATA_BITS-1:0] data_out_11,
  output logic [DATA_BITS-1:0] data_out_12,
  output logic [DATA_BITS-1:0] data_out_13,
  output logic [DATA_BITS-1:0] data_out_14,
  output logic [DATA_BITS-1:0] data_out_15,
  output logic [DATA_BITS-1:0] data_out_16,
  output logic [DATA_BITS-1:0] data_out_17,
  output logic [DATA_BITS-1:0] data_out_18,
  output logic [DATA_BITS-1:0] data_out_19,
  output logic [DATA_BITS-1:0] data_out_20,
  output logic [DATA_BITS-1:0] data_out_21,
  output logic [DATA_BITS-1:0] data_out_22,
  output logic [DATA_BITS-1:0] data_out_23,
  output logic [DATA_BITS-1:0] data_out_24,
  output logic                 valid_out_buf,
  output logic                 frame_done
);

  localparam int SR_LEN = 4*WIDTH + 5;
  localparam int CW     = $clog2(WIDTH);
  localparam int RW     = $clog2(HEIGHT);

  logic [DATA_BITS-1:0] sr  [SR_LEN];
  logic [DATA_BITS-1:0] win [25];
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic                 sof;
  logic                 col_last;
  logic                 row_last;
  logic                 win_hit;

`ifdef CONV2_BUF_SOF_EN
  assign sof = sof_in;
`else
  assign sof = 1'b0;
`endif

  assign col_last = (col == CW'(WIDTH - 1));
  assign row_last = (row == RW'(HEIGHT - 1));
  // Window test uses the pre-increment position of the pixel being accepted,
  // so a window can never straddle a row or frame edge.
  assign win_hit  = valid_in & ~sof & (row >= RW'(4)) & (col >= CW'(4));

  // Pixel history: sr[0] is the newest accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SR_LEN; k++) sr[k] <= '0;
    end else if (valid_in) begin
      sr[0] <= data_in;
      for (int unsigned k = 1; k < SR_LEN; k++) sr[k] <= sr[k-1];
    end
  end

  // Window taps registered from the post-shift view of sr: tap t of the
  // shifted register is sr[t-1] now, and tap 0 is data_in itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 25; k++) win[k] <= '0;
    end else if (valid_in) begin
      for (int unsigned k = 0; k < 24; k++)
        win[k] <= sr[(4 - k/5)*WIDTH + (4 - k%5) - 1];
      win[24] <= data_in;
    end
  end

  // Raster counters plus the window and end-of-frame pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row           <= '0;
      col           <= '0;
      valid_out_buf <= 1'b0;
      frame_done    <= 1'b0;
    end else if (valid_in) begin
      valid_out_buf <= win_hit;
      frame_done    <= ~sof & row_last & col_last;
      if (sof) begin
        row <= '0;
        col <= CW'(1);
      end else if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else begin
      valid_out_buf <= 1'b0;
      frame_done    <= 1'b0;
    end
  end

  assign data_out_0  = win[0];
  assign data_out_1  = win[1];
  assign data_out_2  = win[2];
  assign data_out_3  = win[3];
  assign data_out_4  = win[4];
  assign data_out_5  = win[5];
  assign data_out_6  = win[6];
  assign data_out_7  = win[7];
  assign data_out_8  = win[8];
  assign data_out_9  = win[9];
  assign data_out_10 = win[10];
  assign data_out_11 = win[11];
  assign data_out_12 = win[12];
  assign data_out_13 = win[13];
  assign data_out_14 = win[14];
  assign data_out_15 = win[15];
  assign data_out_16 = win[16];
  assign data_out_17 = win[17];
  assign data_out_18 = win[18];
  assign data_out_19 = win[19];
  assign data_out_20 = win[20];
  assign data_out_21 = win[21];
  assign data_out_22 = win[22];
  assign data_out_23 = win[23];
  assign data_out_24 = win[24];

endmodule

// File: tb/tb_conv2_buf.sv
// Self-checking bench for conv2_buf at default parameters (12x12, 12-bit).
// Reference model: a 2-D image of the current frame plus raster position;
// each window is read straight out of that image.
module tb_conv2_buf;

  localparam int W = 12;
  localparam int H = 12;
`ifdef CONV2_BUF_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  typedef struct {
    int          pulse;
    int          tap;
    logic [11:0] val;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [11:0] data_in = '0;
`ifdef CONV2_BUF_SOF_EN
  logic        sof_in = 1'b0;
`endif
  logic [11:0] dout [25];
  logic        valid_out_buf;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [11:0] img [H][W];
  logic [11:0] exp_win [25];
  logic        exp_valid = 1'b0;
  logic        exp_fd = 1'b0;
  logic        win_known = 1'b1;
  int          mr = 0;
  int          mc = 0;
  int          acc_cnt = 0;

  // capture of observed pulses
  logic [11:0] cap [2048][25];
  int          pulse_acc [2048];
  int          fd_acc [64];
  int          fd_pulse [64];
  int          pulse_total = 0;
  int          fd_total = 0;

  always #5 clk = ~clk;

  conv2_buf #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(12)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
`ifdef CONV2_BUF_SOF_EN
    .sof_in(sof_in),
`endif
    .data_out_0(dout[0]),   .data_out_1(dout[1]),   .data_out_2(dout[2]),
    .data_out_3(dout[3]),   .data_out_4(dout[4]),   .data_out_5(dout[5]),
    .data_out_6(dout[6]),   .data_out_7(dout[7]),   .data_out_8(dout[8]),
    .data_out_9(dout[9]),   .data_out_10(dout[10]), .data_out_11(dout[11]),
    .data_out_12(dout[12]), .data_out_13(dout[13]), .data_out_14(dout[14]),
    .data_out_15(dout[15]), .data_out_16(dout[16]), .data_out_17(dout[17]),
    .data_out_18(dout[18]), .data_out_19(dout[19]), .data_out_20(dout[20]),
    .data_out_21(dout[21]), .data_out_22(dout[22]), .data_out_23(dout[23]),
    .data_out_24(dout[24]),
    .valid_out_buf(valid_out_buf), .frame_done(frame_done)
  );

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, req, req, $time);
  endtask

  task automatic check_outputs();
    chk("valid_out_buf", int'(valid_out_buf), int'(exp_valid));
    chk("frame_done", int'(frame_done), int'(exp_fd));
    if (win_known)
      for (int k = 0; k < 25; k++)
        chk($sformatf("data_out_%0d", k), int'(dout[k]), int'(exp_win[k]));
  endtask

  task automatic model_reset();
    mr = 0; mc = 0;
    exp_valid = 1'b0; exp_fd = 1'b0; win_known = 1'b1;
    for (int k = 0; k < 25; k++) exp_win[k] = '0;
  endtask

  // one clock: drive, update model at the edge, compare at the falling edge
  task automatic tick(input logic v, input logic [11:0] d, input logic s);
    logic hit;
    valid_in = v;
    data_in  = d;
`ifdef CONV2_BUF_SOF_EN
    sof_in   = s;
`endif
    @(posedge clk);
    hit = v && s && SOF_EN;
    if (!v) begin
      exp_valid = 1'b0;
      exp_fd    = 1'b0;
    end else begin
      if (hit) begin mr = 0; mc = 0; end
      img[mr][mc] = d;
      acc_cnt++;
      exp_valid = !hit && mr >= 4 && mc >= 4;
      exp_fd    = !hit && mr == H-1 && mc == W-1;
      if (exp_valid) begin
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            exp_win[5*i+j] = img[mr-4+i][mc-4+j];
        win_known = 1'b1;
      end else begin
        win_known = 1'b0;
      end
      mc++;
      if (mc == W) begin
        mc = 0; mr++;
        if (mr == H) mr = 0;
      end
    end
    @(negedge clk);
    if (valid_out_buf && pulse_total < 2048) begin
      cap[pulse_total] = dout;
      pulse_acc[pulse_total] = acc_cnt;
      pulse_total++;
    end
    if (frame_done && fd_total < 64) begin
      fd_acc[fd_total] = acc_cnt;
      fd_pulse[fd_total] = pulse_total;
      fd_total++;
    end
    check_outputs();
  endtask

  // mode 0: ramp 12*r+c, 1: all 12'hFFF, 2: random data with random gaps
  task automatic send_frame(input int mode, input bit toggle);
    logic [11:0] d;
    for (int p = 0; p < W*H; p++) begin
      case (mode)
        0:       d = 12'(p);
        1:       d = 12'hFFF;
        default: d = 12'($urandom);
      endcase
      tick(1'b1, d, 1'b0);
      if (toggle) tick(1'b0, 12'($urandom), 1'b0);
      if (mode == 2 && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) tick(1'b0, 12'($urandom), 1'b0);
    end
  endtask

  chk_t tbl [9];

  initial begin
    int bp, bf, b2, ba;

    tbl[0] = '{0, 0, 12'd0};    tbl[1] = '{0, 12, 12'd26};
    tbl[2] = '{0, 24, 12'd52};  tbl[3] = '{1, 24, 12'd53};
    tbl[4] = '{8, 24, 12'd64};  tbl[5] = '{8, 0, 12'd12};
    tbl[6] = '{63, 24, 12'd143}; tbl[7] = '{63, 0, 12'd91};
    tbl[8] = '{63, 12, 12'd117};

    // reset state
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // 1: ramp frame, valid held high
    bp = pulse_total; bf = fd_total;
    send_frame(0, 1'b0);
    chk("t1_pulses", pulse_total - bp, 64);
    chk("t1_frame_done_count", fd_total - bf, 1);
    chk("t1_fd_with_last_pulse", fd_pulse[bf], bp + 64);
    for (int e = 0; e < 9; e++)
      chk($sformatf("t1_tbl%0d_pulse%0d_tap%0d", e, tbl[e].pulse, tbl[e].tap),
          int'(cap[bp + tbl[e].pulse][tbl[e].tap]), int'(tbl[e].val));

    // 2: same frame with valid toggling
    b2 = pulse_total;
    send_frame(0, 1'b1);
    chk("t2_pulses", pulse_total - b2, 64);
    for (int q = 0; q < 64; q++)
      for (int k = 0; k < 25; k++)
        chk($sformatf("t2_win%0d_tap%0d", q, k),
            int'(cap[b2 + q][k]), int'(cap[bp + q][k]));

    // 3: two frames back to back
    b2 = pulse_total; bf = fd_total;
    send_frame(0, 1'b0);
    send_frame(0, 1'b0);
    chk("t3_frame_done_count", fd_total - bf, 2);
    chk("t3_fd_spacing", fd_acc[bf+1] - fd_acc[bf], 144);
    for (int k = 0; k < 25; k++)
      chk($sformatf("t3_first_win_tap%0d", k),
          int'(cap[b2 + 64][k]), int'(cap[b2][k]));

    // 4: asynchronous reset mid-cycle after pixel 70
    for (int p = 0; p <= 70; p++) tick(1'b1, 12'(p), 1'b0);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    bp = pulse_total;
    send_frame(0, 1'b0);
    chk("t4_pulses", pulse_total - bp, 64);
    chk("t4_last_tap24", int'(cap[bp + 63][24]), 143);

    // 5: all -1 pixels
    bp = pulse_total;
    send_frame(1, 1'b0);
    chk("t5_pulses", pulse_total - bp, 64);
    for (int q = 0; q < 64; q++)
      for (int k = 0; k < 25; k++)
        chk($sformatf("t5_win%0d_tap%0d", q, k), int'(cap[bp + q][k]), 12'hFFF);

    // random frames with random gaps against the model
    for (int f = 0; f < 3; f++) begin
      bp = pulse_total; bf = fd_total;
      send_frame(2, 1'b0);
      chk("rand_pulses", pulse_total - bp, 64);
      chk("rand_frame_done", fd_total - bf, 1);
    end

`ifdef CONV2_BUF_SOF_EN
    // 6: start-of-frame re-alignment mid-frame
    bp = pulse_total; bf = fd_total; ba = acc_cnt;
    for (int p = 0; p < 30; p++) tick(1'b1, 12'(p), 1'b0);
    tick(1'b1, 12'd0, 1'b1);
    for (int p = 1; p < 144; p++) tick(1'b1, 12'(p), 1'b0);
    chk("t6_pulses", pulse_total - bp, 64);
    chk("t6_first_pulse_pixel", pulse_acc[bp] - ba, 30 + 53);
    chk("t6_first_tap24", int'(cap[bp][24]), 52);
    chk("t6_frame_done_count", fd_total - bf, 1);
    chk("t6_fd_pixel", fd_acc[bf] - ba, 30 + 144);
`else
    ba = acc_cnt;
    chk("accepted_total", ba, 144*9 + 71);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
